// File: rtl/wf_btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wf_btn_pkg
// Brief    : Shared debounce state encodings, default timing and helpers for
//            the waveform push-button conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package wf_btn_pkg;

  // Per-channel debounce state: bit 1 is the accepted level, bit 0 marks a
  // pending change that is still being qualified.
  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_e;

  // Defaults assume a 25 MHz system clock.
  localparam int DEFAULT_NUM_BTNS        = 3;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;    // 10 ms
  localparam int DEFAULT_REPEAT_DELAY    = 12500000;  // 500 ms
  localparam int DEFAULT_REPEAT_PERIOD   = 2500000;   // 100 ms

  // Width of a counter that must hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : wf_btn_pkg
`default_nettype wire

// File: rtl/wf_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : wf_debounce_channel
// Brief    : One button channel: two-flop synchroniser, debounce counter and
//            state, press request, plus an optional hold/auto-repeat counter.
//            Optional feature macro: WF_BTN_AUTOREPEAT_EN
// Revision : 1.0 - initial release
// ============================================================================
module wf_debounce_channel
  import wf_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic level_o,
  output logic req_o
);

  localparam int                C_CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject timing values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("wf_debounce_channel: illegal timing parameters");
  end

  logic               sync1_q, sync2_q;
  btn_state_e         state_q, state_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic               w_level, w_mismatch, w_done, w_press_req;

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign w_level     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign w_mismatch  = sync2_q ^ w_level;
  // Level flips on the edge after the counter has seen enough stable cycles.
  assign w_done      = w_mismatch && (cnt_q == C_CNT_LAST);
  assign w_press_req = w_done && !w_level;

  // Debounce state and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: any return to the accepted level restarts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = (w_mismatch && !w_done) ? cnt_q + 1'b1 : '0;
    case (state_q)
      RELEASED:     if (w_mismatch) state_d = w_done ? PRESSED : PRESS_WAIT;
      PRESS_WAIT:   if (!w_mismatch) state_d = RELEASED;
                    else if (w_done) state_d = PRESSED;
      PRESSED:      if (w_mismatch) state_d = w_done ? RELEASED : RELEASE_WAIT;
      RELEASE_WAIT: if (!w_mismatch) state_d = PRESSED;
                    else if (w_done) state_d = RELEASED;
      default:      state_d = RELEASED;
    endcase
  end

  assign level_o = w_level;

`ifdef WF_BTN_AUTOREPEAT_EN
  localparam int C_HOLD_W =
    cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [C_HOLD_W-1:0] C_DELAY_LAST  = C_HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [C_HOLD_W-1:0] C_PERIOD_LAST = C_HOLD_W'(REPEAT_PERIOD - 1);

  logic [C_HOLD_W-1:0] hold_q, hold_d;
  logic                rpt_q, rpt_d;
  logic                w_rpt_req;

  // Hold counter and first-repeat-done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      rpt_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rpt_q  <= rpt_d;
    end
  end

  // Count from the press; first repeat after the delay, then every period.
  always_comb begin
    hold_d    = hold_q + 1'b1;
    rpt_d     = rpt_q;
    w_rpt_req = 1'b0;
    if (!w_level || w_done) begin
      // Not held, or a release is being accepted this edge.
      hold_d = '0;
      rpt_d  = 1'b0;
    end else if ((!rpt_q && hold_q == C_DELAY_LAST) ||
                 ( rpt_q && hold_q == C_PERIOD_LAST)) begin
      w_rpt_req = 1'b1;
      hold_d    = '0;
      rpt_d     = 1'b1;
    end
  end

  assign req_o = w_press_req | w_rpt_req;
`else
  assign req_o = w_press_req;
`endif

endmodule : wf_debounce_channel
`default_nettype wire

// File: rtl/wf_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : wf_button_conditioner
// Brief    : Synchronises and debounces the board push-buttons and emits a
//            one-hot single-cycle press pulse (lowest index wins, others are
//            dropped and flagged) plus debounced levels.
//            Optional feature macro: WF_BTN_AUTOREPEAT_EN (hold auto-repeat)
// Revision : 1.0 - initial release
// ============================================================================
module wf_button_conditioner
  import wf_btn_pkg::*;
#(
  parameter int NUM_BTNS        = DEFAULT_NUM_BTNS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,          // asynchronous, active low
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse,
  output logic                btn_dropped
);

  logic [NUM_BTNS-1:0] w_req;
  logic [NUM_BTNS-1:0] pulse_d, pulse_q;
  logic                dropped_d, dropped_q;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
    wf_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk_i     (clk),
      .rst_ni    (rst),
      .btn_raw_i (btn_raw[gi]),
      .level_o   (btn_level[gi]),
      .req_o     (w_req[gi])
    );
  end

  // Lowest-index request wins; the rest are discarded, not deferred.
  always_comb begin
    pulse_d = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        pulse_d    = '0;
        pulse_d[i] = 1'b1;
      end
    end
    dropped_d = |(w_req & ~pulse_d);
  end

  // Output registers, updated on the same edge as the debounced levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      pulse_q   <= pulse_d;
      dropped_q <= dropped_d;
    end
  end

  assign btn_pulse   = pulse_q;
  assign btn_dropped = dropped_q;

endmodule : wf_button_conditioner
`default_nettype wire

// File: doc/wf_button_conditioner.md
Name: wf_button_conditioner

Overview:
- Front end for the waveform display-limits controller. It sits directly upstream and feeds its btn1/btn2/btn3 inputs.
- Synchronises, debounces and edge-detects the raw board push-buttons.
- Produces a single-cycle, strictly one-hot press pulse per debounced press, so the downstream state machine sees each press exactly once.
- Also exports debounced levels for status LEDs.

Parameters:
- NUM_BTNS, 3, number of button channels; index 0 = btn1, 1 = btn2, 2 = btn3.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); must be >= 2.
- REPEAT_DELAY, 12500000, hold time before first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 2500000, spacing of subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_raw  in  NUM_BTNS  asynchronous raw button inputs, active-high
- btn_level  out  NUM_BTNS  debounced button levels, registered
- btn_pulse  out  NUM_BTNS  one-hot or zero; high for exactly one cycle per accepted press, registered
- btn_dropped  out  1  high for one cycle when a simultaneous press was discarded by arbitration

Behaviour:
- Reset: rst low forces all synchroniser flops, counters, btn_level, btn_pulse and btn_dropped to 0 immediately. No clock is needed.
- Synchroniser: two flops per channel. The synchronised value (sync) follows btn_raw with 2 cycles of latency.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYCLES):
  - While sync == btn_level, the counter clears to 0.
  - While sync != btn_level, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync != btn_level, btn_level toggles on the next edge and the counter clears.
  - Any return of sync to btn_level before that point clears the counter (bounce rejection).
- Latency: a clean raw edge appears on btn_level exactly 2+DEBOUNCE_CYCLES cycles later.
- Per-channel states:
  - RELEASED: level 0, sync 0.
  - PRESS_WAIT: level 0, sync 1, counting.
  - PRESSED: level 1.
  - RELEASE_WAIT: level 1, sync 0, counting.
  - Transitions follow the counter rules above.
- Press request: a channel raises a request in the same cycle its btn_level rises 0->1. Falling edges raise no request.
- Arbitration:
  - btn_pulse is the lowest-index request, registered alongside btn_level, so btn_pulse[i] is high on the first cycle btn_level[i] reads 1.
  - Other requests in that same cycle are discarded, not deferred, and btn_dropped pulses.
  - btn_pulse is never multi-hot.
- Reset mid-operation: all progress is lost. After rst deasserts, a button still held is treated as a fresh press and pulses 2+DEBOUNCE_CYCLES cycles later.

Optional Feature:
- Macro: WF_BTN_AUTOREPEAT_EN.
- Defined:
  - A per-channel hold counter starts at the press pulse.
  - While btn_level[i] stays 1, the channel raises a repeat request REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
  - Repeat requests go through the same lowest-index arbitration as press requests.
  - The hold counter clears when btn_level falls. No repeats occur after release is accepted.
- Undefined: no hold counters are built, and exactly one pulse is produced per press.

Decomposition:
- Package wf_btn_pkg holds:
  - the 2-bit debounce state encodings RELEASED=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11;
  - the default timing constants.
- Sub-module wf_debounce_channel contains the synchroniser, debounce counter, state and (optional) repeat counter for one button.
  - It outputs level and req.
  - It is instantiated NUM_BTNS times via generate.
- Top level: arbitration, output registers and btn_dropped.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3. Cycle numbers are counted from the raw edge at cycle 0.
- Clean press: btn_raw=3'b001 at cycle 0, held 20 cycles -> btn_level[0] rises at cycle 6; btn_pulse=3'b001 only at cycle 6. Release at cycle 20 -> btn_level[0] falls at cycle 26; no pulse.
- Bounce: btn_raw[1] toggles 1,0,1,0,1 every 2 cycles, stable 1 from cycle 8 -> exactly one btn_pulse=3'b010, at cycle 14; btn_dropped stays 0.
- Glitch: btn_raw[2] high for cycles 0-2 only -> btn_level and btn_pulse stay 0 throughout.
- Simultaneous press: btn_raw=3'b101 at cycle 0 -> at cycle 6, btn_pulse=3'b001, btn_level=3'b101, btn_dropped=1; no later pulse for channel 2.
- Reset mid-debounce: btn_raw[0] high from cycle 0; rst low at cycle 4 and high at cycle 6 -> all outputs 0 during reset; btn_pulse=3'b001 at cycle 12.
- Autorepeat: btn_raw[0] held cycles 0-29.
  - With WF_BTN_AUTOREPEAT_EN: pulses at cycles 6, 16, 19, 22, 25, 28, 31, 34; none after btn_level falls at cycle 36.
  - Without the macro: single pulse at cycle 6.
